i2s_tx: RTL and testbench
=========================

Name: i2s_tx

Overview:
Downstream stage of the sample buffer. Consumes 24-bit interleaved samples from an AXI-Stream interface and drives them to the codec DAC as a Philips I2S stream. The order is left then right, MSB first, with a one-bit delay after each LRCLK edge. Generates BCLK and LRCLK from the system clock, so the block is the master for the DAC serial port.

Parameters:
DWIDTH, 24, sample width in bits; must be < SLOT_BITS.
SLOT_BITS, 32, BCLK periods per channel slot; frame = 2*SLOT_BITS BCLKs.
BCLK_DIV, 16, clk cycles per BCLK half-period; must be >= 2 (100 MHz gives 3.125 MHz BCLK and 48.83 kHz frame rate).

Ports:
clk  in  1  system clock, single clock domain.
reset_n  in  1  asynchronous, active-low reset.
din  Axis_If slave  DWIDTH  sample stream (data/valid/ready); words alternate L, R, L, R...
bclk  out  1  I2S bit clock.
lrclk  out  1  I2S word select; 0 = left, 1 = right.
sdata  out  1  I2S serial data.
underflow  out  1  one-clk pulse when a slot fetch finds din.valid low.

Behaviour:
- Reset values (async on reset_n low):
  - bclk=0, lrclk=1, sdata=0, din.ready=0, underflow=0.
  - div_cnt=0, bit_cnt=2*SLOT_BITS-1, shift register=0.
- div_cnt counts 0..BCLK_DIV-1 every clk. At terminal count, bclk toggles and div_cnt wraps to 0.
- tick_fall is the clk cycle where div_cnt==BCLK_DIV-1 and bclk==1, i.e. a BCLK falling edge is registered.
- All of the following update only on tick_fall:
  - bit_cnt increments mod 2*SLOT_BITS.
  - lrclk <= next bit_cnt MSB (bit_cnt / SLOT_BITS).
  - sdata <= next bit.
- Slot index k = next bit_cnt mod SLOT_BITS.
  - sdata = 0 at k=0 (one-bit I2S delay).
  - sdata = sample[DWIDTH-k] for k=1..DWIDTH.
  - sdata = 0 for k=DWIDTH+1..SLOT_BITS-1.
- Fetch:
  - din.ready=1 for exactly the one tick_fall cycle whose next k==0; 0 in all other cycles.
  - din.valid high in that cycle: din.data is captured into the shift register (handshake completes).
  - din.valid low: shift register loads 0 and underflow pulses for that one cycle.
  - A word offered outside the fetch cycle is not accepted; the upstream buffer holds it.
- First fetch after reset release:
  - Occurs at the 2*BCLK_DIV-th rising clk edge (first BCLK fall). This is a left-slot fetch with lrclk going 0.
  - MSB appears on sdata one BCLK later.
- Fetch-to-MSB latency: 2*BCLK_DIV clk cycles.
- Framing: one frame = 2*SLOT_BITS BCLKs = 2 accepted words. Throughput = 2 words per 2*SLOT_BITS*2*BCLK_DIV clk.
- Channel phase: the word fetched when lrclk goes 0 is always the left sample. There is no resynchronisation; upstream keeps L/R interleave.
- Reset mid-frame: all outputs return immediately to reset values. The next frame starts cleanly at left with no partial word emitted.
- Simultaneous events: din.valid rising in the fetch cycle itself is accepted; the state of valid in the previous cycle is irrelevant.

Optional Feature:
I2S_TX_UNDERFLOW_HOLD_EN
- Defined: on underflow the shift register reloads the last successfully accepted word for that channel (separate L and R hold registers, reset to 0) instead of 0. The underflow pulse is still generated.
- Undefined: underflow outputs a zero (silent) slot; no hold registers are synthesised.

Test Plan:
- BCLK_DIV=16, din.valid=1 with incrementing data from 0 → bclk period 32 clk, lrclk period 2048 clk. din.ready pulses every 1024 clk, one cycle wide. Slots carry 0x000000, 0x000001, 0x000002...
- Send data 0xA5A5A5 (L) and 0x5A5A5A (R) → sampling sdata on bclk rising edges gives, per slot: 0, then the 24 data bits MSB first, then 7 zeros. lrclk=0 during the left slot.
- din.valid=0 for one fetch → underflow high exactly 1 clk and that slot is all zeros. With I2S_TX_UNDERFLOW_HOLD_EN, the slot repeats the previous same-channel word.
- din.valid raised only in the fetch cycle → word accepted. Valid held high with changing data between fetches → only the fetch-cycle value appears.
- Assert reset_n low mid right slot (bit 40) → outputs 0/1/0/0 immediately. After release, the first ready is at the 32nd clk edge and the first output slot is left.
- BCLK_DIV=2, SLOT_BITS=32, DWIDTH=24 → bclk period 4 clk, correct bit alignment, no dropped handshakes over 100 frames.

Source files
------------

// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx
// Summary  : Philips I2S master transmitter. Pulls interleaved L/R samples from
//            a ready/valid stream once per channel slot and shifts them out MSB
//            first, one BCLK after each LRCLK edge. BCLK and LRCLK are derived
//            from clk by a free-running divider.
// Options  : I2S_TX_UNDERFLOW_HOLD_EN - on underflow replay the last accepted
//            word of the same channel instead of sending a silent slot.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_tx #(
  parameter int DWIDTH    = 24,
  parameter int SLOT_BITS = 32,
  parameter int BCLK_DIV  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DWIDTH-1:0] i_din_data,
  input  logic              i_din_valid,
  output logic              o_din_ready,
  output logic              o_bclk,
  output logic              o_lrclk,
  output logic              o_sdata,
  output logic              o_underflow
);

  localparam int c_DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int c_CNT_W = $clog2(2 * SLOT_BITS);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(BCLK_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(2 * SLOT_BITS - 1);
  localparam logic [c_CNT_W-1:0] c_SLOT      = c_CNT_W'(SLOT_BITS);
  localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DWIDTH);

  logic [c_DIV_W-1:0] r_div_cnt;
  logic               r_bclk;
  logic [c_CNT_W-1:0] r_bit_cnt;
  logic               r_lrclk;
  logic               r_sdata;
  logic [DWIDTH-1:0]  r_shift;

  logic               w_tick_fall;
  logic [c_CNT_W-1:0] w_bit_nxt;
  logic               w_lr_nxt;
  logic [c_CNT_W-1:0] w_k;
  logic               w_data_slot;
  logic               w_fetch;
  logic [DWIDTH-1:0]  w_load;

  // Everything in the serial domain advances on the clk cycle that drops BCLK
  assign w_tick_fall = (r_div_cnt == c_DIV_LAST) && r_bclk;
  assign w_bit_nxt   = (r_bit_cnt == c_CNT_LAST) ? '0 : r_bit_cnt + c_CNT_W'(1);
  assign w_lr_nxt    = (w_bit_nxt >= c_SLOT);
  assign w_k         = w_lr_nxt ? (w_bit_nxt - c_SLOT) : w_bit_nxt;
  // Slot position 0 is the I2S one-bit delay; payload occupies 1..DWIDTH
  assign w_data_slot = (w_k != '0) && (w_k <= c_DATA_LAST);
  assign w_fetch     = w_tick_fall && (w_k == '0);

`ifdef I2S_TX_UNDERFLOW_HOLD_EN
  logic [DWIDTH-1:0] r_hold_l;
  logic [DWIDTH-1:0] r_hold_r;

  // Remember the last word accepted for each channel to replay on underflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_l <= '0;
      r_hold_r <= '0;
    end else if (w_fetch && i_din_valid) begin
      if (w_lr_nxt) r_hold_r <= i_din_data;
      else          r_hold_l <= i_din_data;
    end
  end

  assign w_load = i_din_valid ? i_din_data : (w_lr_nxt ? r_hold_r : r_hold_l);
`else
  assign w_load = i_din_valid ? i_din_data : '0;
`endif

  // Free-running divider producing a 50% duty BCLK
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
    end else if (r_div_cnt == c_DIV_LAST) begin
      r_div_cnt <= '0;
      r_bclk    <= ~r_bclk;
    end else begin
      r_div_cnt <= r_div_cnt + c_DIV_W'(1);
    end
  end

  // Frame position, word select and serial data all change on BCLK falls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt <= c_CNT_LAST;
      r_lrclk   <= 1'b1;
      r_sdata   <= 1'b0;
      r_shift   <= '0;
    end else if (w_tick_fall) begin
      r_bit_cnt <= w_bit_nxt;
      r_lrclk   <= w_lr_nxt;
      if (w_fetch) begin
        r_shift <= w_load;
        r_sdata <= 1'b0;
      end else if (w_data_slot) begin
        r_sdata <= r_shift[DWIDTH-1];
        r_shift <= {r_shift[DWIDTH-2:0], 1'b0};
      end else begin
        r_sdata <= 1'b0;
      end
    end
  end

  // Ready is open only in the fetch cycle, so an early word simply waits
  assign o_din_ready = w_fetch;
  assign o_underflow = w_fetch && !i_din_valid;
  assign o_bclk      = r_bclk;
  assign o_lrclk     = r_lrclk;
  assign o_sdata     = r_sdata;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_tx
// Summary  : Directed bench for i2s_tx. A slot table drives the default
//            configuration (BCLK_DIV=16); a second instance with BCLK_DIV=2
//            streams 100 frames of patterned words concurrently.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_tx;

  localparam int DW = 24;

  typedef struct {
    logic [DW-1:0] data;
    logic          valid;
    logic [DW-1:0] exp_w;
    logic [DW-1:0] exp_hold;
    logic          exp_lr;
    logic          exp_uf;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [DW-1:0] din_data;
  logic          din_valid;
  logic          din_ready, bclk, lrclk, sdata, underflow;

  logic          reset_nb;
  logic [DW-1:0] din_data_b;
  logic          din_valid_b;
  logic          din_ready_b, bclk_b, lrclk_b, sdata_b, underflow_b;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_fetch = -1;
  bit   done_b = 1'b0;
  vec_t vecs[12];

  i2s_tx #(.DWIDTH(24), .SLOT_BITS(32), .BCLK_DIV(16)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .i_din_data(din_data), .i_din_valid(din_valid), .o_din_ready(din_ready),
    .o_bclk(bclk), .o_lrclk(lrclk), .o_sdata(sdata), .o_underflow(underflow)
  );

  i2s_tx #(.DWIDTH(24), .SLOT_BITS(32), .BCLK_DIV(2)) u_dut_b (
    .clk(clk), .reset_n(reset_nb),
    .i_din_data(din_data_b), .i_din_valid(din_valid_b), .o_din_ready(din_ready_b),
    .o_bclk(bclk_b), .o_lrclk(lrclk_b), .o_sdata(sdata_b), .o_underflow(underflow_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clk and settle just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Release reset at posedge+1 and count edges until ready opens
  task automatic release_reset(input string tag);
    int n = 0;
    reset_n = 1'b1;
    while (n < 100 && !din_ready) begin
      step();
      n++;
    end
    check({tag, "_first_ready_edge"}, 64'(n), 64'd31);
    last_fetch = -1;
  endtask

  // Wait for the fetch, offer the vector's word, then collect nbits BCLK-rise samples
  task automatic run_slot(input vec_t v, input int nbits, input string tag);
    bit            ok = 1'b0;
    logic [31:0]   got = '0;
    logic [DW-1:0] exp_w;
    logic          prev_b;
    int            nb = 0;
    int            last_rise = -1;
    int            per_bad = 0;
    int            lr_bad = 0;
    int            stray = 0;
`ifdef I2S_TX_UNDERFLOW_HOLD_EN
    exp_w = v.exp_hold;
`else
    exp_w = v.exp_w;
`endif
    for (int i = 0; i < 1200 && !ok; i++) begin
      if (din_ready) ok = 1'b1;
      else begin
        din_valid = 1'b1;
        din_data  = DW'($urandom);
        step();
      end
    end
    if (!ok) begin
      check({tag, "_fetch_timeout"}, 64'd0, 64'd1);
      return;
    end
    if (last_fetch >= 0) check({tag, "_fetch_gap"}, 64'(cyc - last_fetch), 64'd1024);
    last_fetch = cyc;
    din_data  = v.data;
    din_valid = v.valid;
    #1;
    check({tag, "_underflow"}, 64'(underflow), 64'(v.exp_uf));
    step();
    din_valid = 1'b1;
    din_data  = DW'($urandom);
    check({tag, "_lrclk_at_fetch"}, 64'(lrclk), 64'(v.exp_lr));
    prev_b = bclk;
    for (int i = 0; i < nbits * 32 + 40 && nb < nbits; i++) begin
      step();
      if (din_ready || underflow) stray++;
      if (bclk && !prev_b) begin
        if (last_rise >= 0 && cyc - last_rise != 32) per_bad++;
        last_rise = cyc;
        got = {got[30:0], sdata};
        nb++;
        if (lrclk !== v.exp_lr) lr_bad++;
      end
      prev_b   = bclk;
      din_data = DW'($urandom);
    end
    check({tag, "_bit_count"}, 64'(nb), 64'(nbits));
    if (nbits == 32) check({tag, "_bits"}, 64'(got), 64'({1'b0, exp_w, 7'b0}));
    check({tag, "_lrclk_in_slot"}, 64'(lr_bad), 64'd0);
    check({tag, "_stray_ready_uf"}, 64'(stray), 64'd0);
    check({tag, "_bclk_period"}, 64'(per_bad), 64'd0);
  endtask

  // Main sequence on the BCLK_DIV=16 instance
  initial begin
    int wait_i;
    vecs[0]  = '{24'h000000, 1'b1, 24'h000000, 24'h000000, 1'b0, 1'b0};
    vecs[1]  = '{24'h000001, 1'b1, 24'h000001, 24'h000001, 1'b1, 1'b0};
    vecs[2]  = '{24'h000002, 1'b1, 24'h000002, 24'h000002, 1'b0, 1'b0};
    vecs[3]  = '{24'h000003, 1'b1, 24'h000003, 24'h000003, 1'b1, 1'b0};
    vecs[4]  = '{24'hA5A5A5, 1'b1, 24'hA5A5A5, 24'hA5A5A5, 1'b0, 1'b0};
    vecs[5]  = '{24'h5A5A5A, 1'b1, 24'h5A5A5A, 24'h5A5A5A, 1'b1, 1'b0};
    vecs[6]  = '{24'h123456, 1'b0, 24'h000000, 24'hA5A5A5, 1'b0, 1'b1};
    vecs[7]  = '{24'h654321, 1'b0, 24'h000000, 24'h5A5A5A, 1'b1, 1'b1};
    vecs[8]  = '{24'h800001, 1'b1, 24'h800001, 24'h800001, 1'b0, 1'b0};
    vecs[9]  = '{24'hFFFFFF, 1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b0};
    vecs[10] = '{24'h000000, 1'b0, 24'h000000, 24'h800001, 1'b0, 1'b1};
    vecs[11] = '{24'hC00003, 1'b1, 24'hC00003, 24'hC00003, 1'b1, 1'b0};

    reset_n   = 1'b0;
    din_valid = 1'b0;
    din_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({bclk, lrclk, sdata, din_ready, underflow}), 64'(5'b01000));
    release_reset("por");

    for (int i = 0; i < 12; i++) run_slot(vecs[i], 32, $sformatf("slot%0d", i));

    // Reset in the middle of a right slot, then confirm a clean left restart
    run_slot('{24'h111111, 1'b1, 24'h111111, 24'h111111, 1'b0, 1'b0}, 32, "pre_reset_l");
    run_slot('{24'h222222, 1'b1, 24'h222222, 24'h222222, 1'b1, 1'b0}, 8, "aborted_r");
    #3;
    reset_n = 1'b0;
    #1;
    check("midreset_outputs", 64'({bclk, lrclk, sdata, din_ready, underflow}), 64'(5'b01000));
    repeat (2) @(posedge clk);
    #1;
    check("midreset_held", 64'({bclk, lrclk, sdata, din_ready, underflow}), 64'(5'b01000));
    release_reset("midreset");
    run_slot('{24'h333333, 1'b1, 24'h333333, 24'h333333, 1'b0, 1'b0}, 32, "post_reset_l");
    run_slot('{24'h444444, 1'b1, 24'h444444, 24'h444444, 1'b1, 1'b0}, 32, "post_reset_r");

    wait_i = 0;
    while (wait_i < 40000 && !done_b) begin
      @(posedge clk);
      wait_i++;
    end
    check("b_done", 64'(done_b), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Fast-divider instance: 100 frames of patterned words with continuous valid
  initial begin
    int            nf = 0;
    int            slot = 0;
    int            nb = 0;
    int            cycb = 0;
    int            lastf = -1;
    int            lastr = -1;
    int            gap_bad = 0;
    int            per_bad = 0;
    int            uf_cnt = 0;
    logic [31:0]   sh = '0;
    logic          prevb = 1'b0;
    logic [DW-1:0] q[$];
    logic [DW-1:0] w;
    logic [7:0]    n8;
    reset_nb    = 1'b0;
    din_valid_b = 1'b0;
    din_data_b  = '0;
    repeat (4) @(posedge clk);
    #1;
    reset_nb    = 1'b1;
    din_valid_b = 1'b1;
    while (slot < 200 && cycb < 30000) begin
      @(posedge clk);
      #1;
      cycb++;
      if (underflow_b) uf_cnt++;
      if (bclk_b && !prevb) begin
        if (lastr >= 0 && cycb - lastr != 4) per_bad++;
        lastr = cycb;
        if (nf > 0) begin
          sh = {sh[30:0], sdata_b};
          nb++;
          if (nb == 32) begin
            w = (q.size() > 0) ? q.pop_front() : 24'h0;
            check($sformatf("b_slot%0d", slot), 64'({lrclk_b, sh}),
                  64'({slot[0], 1'b0, w, 7'b0}));
            nb = 0;
            slot++;
          end
        end
      end
      prevb = bclk_b;
      if (din_ready_b) begin
        if (lastf >= 0 && cycb - lastf != 128) gap_bad++;
        lastf = cycb;
        n8 = 8'(nf);
        din_data_b = {n8, ~n8, n8 ^ 8'h5A};
        q.push_back(din_data_b);
        nf++;
      end else begin
        din_data_b = DW'($urandom);
      end
    end
    check("b_slot_count", 64'(slot), 64'd200);
    check("b_fetch_gap", 64'(gap_bad), 64'd0);
    check("b_bclk_period", 64'(per_bad), 64'd0);
    check("b_underflow", 64'(uf_cnt), 64'd0);
    done_b = 1'b1;
  end

endmodule
`default_nettype wire
